// File: rtl/lm_tracker_pkg.sv
// Shared constants, FSM state encoding and the output token format for lm_tracker.
package lm_tracker_pkg;

    localparam int LM_CAM_LEN = 256;
    localparam int LM_MAX_LEN = 255;
    localparam int LM_LEN_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MATCH,
        ST_FLUSH
    } lm_state_e;

    typedef struct packed {
        logic [LM_CAM_LEN-1:0] vector;
        logic [LM_LEN_W-1:0]   length;
        logic                  last;
    } lm_token_t;

    function automatic lm_token_t mk_token(input logic [LM_CAM_LEN-1:0] vec,
                                           input logic [LM_LEN_W-1:0]   len,
                                           input logic                  last);
        lm_token_t t;
        t.vector = vec;
        t.length = len;
        t.last   = last;
        return t;
    endfunction

endpackage

// File: rtl/lm_tracker_if.sv
// Byte-in / token-out handshake bundle between a CAM front end and the tracker.
interface lm_tracker_if #(
    parameter int CAM_LEN = lm_tracker_pkg::LM_CAM_LEN
);
    logic               in_valid;
    logic               in_ready;
    logic [CAM_LEN-1:0] cam_match;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [CAM_LEN-1:0] or_match_vector;
    logic [7:0]         lm_counter;
    logic               out_last;

    modport master (
        output in_valid, cam_match, in_last, out_ready,
        input  in_ready, out_valid, or_match_vector, lm_counter, out_last
    );

    modport slave (
        input  in_valid, cam_match, in_last, out_ready,
        output in_ready, out_valid, or_match_vector, lm_counter, out_last
    );
endinterface

// File: rtl/lm_token_reg.sv
// One-entry output register: holds a token stable until the consumer takes it.
module lm_token_reg
    import lm_tracker_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load_valid_i,
    input  lm_token_t load_tok_i,
    output logic      load_ready_o,
    output logic      out_valid_o,
    input  logic      out_ready_i,
    output lm_token_t out_tok_o
);

    logic      valid_q;
    lm_token_t tok_q;

    // A consume and a new load can share one cycle, keeping the stream gapless.
    assign load_ready_o = !valid_q || out_ready_i;
    assign out_valid_o  = valid_q;
    assign out_tok_o    = tok_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tok_q   <= '0;
        end else if (load_ready_o) begin
            valid_q <= load_valid_i;
            if (load_valid_i) begin
                tok_q <= load_tok_i;
            end
        end
    end

endmodule

// File: rtl/lm_tracker.sv
// Longest-match run tracker: follows diagonal CAM hits byte by byte and emits
// (surviving vector, run length) tokens, or literal tokens when nothing matches.
module lm_tracker
    import lm_tracker_pkg::*;
#(
    parameter int CAM_LEN = LM_CAM_LEN,
    parameter int MAX_LEN = LM_MAX_LEN
) (
    input  logic         clk,
    input  logic         rst_n,
    lm_tracker_if.slave  bus
);

    localparam logic [7:0] MAX_L = 8'(MAX_LEN);

    lm_state_e          state_q, state_d;
    logic [CAM_LEN-1:0] r_q, r_d;
    logic [7:0]         l_q, l_d;
    lm_token_t          pend_q, pend_d;

    logic               ld_valid, ld_ready, out_valid;
    lm_token_t          ld_tok, out_tok;
    logic               accept, cm_hit, tail_valid;
    lm_token_t          tail_tok;
    logic [CAM_LEN-1:0] n_vec;

    function automatic logic [LM_CAM_LEN-1:0] widen(input logic [CAM_LEN-1:0] v);
        logic [LM_CAM_LEN-1:0] w;
        w = '0;
        w[CAM_LEN-1:0] = v;
        return w;
    endfunction

    assign bus.in_ready = (state_q != ST_FLUSH) && ld_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    // The top bit shifts out and is lost; no wrap back to entry 0.
    assign n_vec        = (r_q << 1) & bus.cam_match;

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        l_d        = l_q;
        pend_d     = pend_q;
        ld_valid   = 1'b0;
        ld_tok     = '0;
        cm_hit     = |bus.cam_match;
        tail_valid = 1'b0;
        tail_tok   = '0;

        case (state_q)
            ST_FLUSH: begin
                if (ld_ready) begin
                    ld_valid = 1'b1;
                    ld_tok   = pend_q;
                    pend_d   = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                if (accept) begin
                    if (state_q == ST_MATCH && n_vec != '0 && l_q < MAX_L) begin
                        if (bus.in_last) begin
                            ld_valid = 1'b1;
                            ld_tok   = mk_token(widen(n_vec), l_q + 8'd1, 1'b1);
                            r_d      = '0;
                            l_d      = '0;
                            state_d  = ST_IDLE;
                        end else begin
                            r_d = n_vec;
                            l_d = l_q + 8'd1;
                        end
                    end else begin
                        // Token the restarting byte produces on its own, if any.
                        tail_valid = !cm_hit || bus.in_last;
                        tail_tok   = cm_hit ? mk_token(widen(bus.cam_match), 8'd1, 1'b1)
                                            : mk_token('0, 8'd0, bus.in_last);
                        if (state_q == ST_MATCH) begin
                            ld_valid = 1'b1;
                            ld_tok   = mk_token(widen(r_q), l_q, 1'b0);
                            if (tail_valid) begin
                                pend_d  = tail_tok;
                                r_d     = '0;
                                l_d     = '0;
                                state_d = ST_FLUSH;
                            end else begin
                                r_d     = bus.cam_match;
                                l_d     = 8'd1;
                                state_d = ST_MATCH;
                            end
                        end else if (tail_valid) begin
                            ld_valid = 1'b1;
                            ld_tok   = tail_tok;
                            r_d      = '0;
                            l_d      = '0;
                            state_d  = ST_IDLE;
                        end else begin
                            r_d     = bus.cam_match;
                            l_d     = 8'd1;
                            state_d = ST_MATCH;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            l_q     <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            l_q     <= l_d;
            pend_q  <= pend_d;
        end
    end

    lm_token_reg u_token_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid_i (ld_valid),
        .load_tok_i   (ld_tok),
        .load_ready_o (ld_ready),
        .out_valid_o  (out_valid),
        .out_ready_i  (bus.out_ready),
        .out_tok_o    (out_tok)
    );

    assign bus.out_valid       = out_valid;
    assign bus.or_match_vector = out_tok.vector[CAM_LEN-1:0];
    assign bus.lm_counter      = out_tok.length;
    assign bus.out_last        = out_tok.last;

endmodule

// File: tb/tb_lm_tracker.sv
// Directed vector bench for lm_tracker: table of single-byte steps plus
// long-run, back-pressure and reset-in-flush sequences.
module tb_lm_tracker;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    lm_tracker_if #(.CAM_LEN(256)) bus ();

    lm_tracker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        iv;
        logic [31:0] cm;
        logic        last;
        logic        ov;
        logic [31:0] vec;
        logic [7:0]  len;
        logic        olast;
        logic        irdy;
    } row_t;

    row_t tbl [20];

    function automatic row_t mk(input logic iv, input logic [31:0] cm, input logic last,
                                input logic ov, input logic [31:0] vec, input logic [7:0] len,
                                input logic olast, input logic irdy);
        row_t r;
        r.iv = iv; r.cm = cm; r.last = last; r.ov = ov;
        r.vec = vec; r.len = len; r.olast = olast; r.irdy = irdy;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_tok(input string nm, input logic [255:0] v, input logic [7:0] len,
                           input logic last);
        chk({nm, ".valid"}, 256'(bus.out_valid), 256'(1'b1));
        chk({nm, ".vec"}, bus.or_match_vector, v);
        chk({nm, ".len"}, 256'(bus.lm_counter), 256'(len));
        chk({nm, ".last"}, 256'(bus.out_last), 256'(last));
    endtask

    task automatic drive(input logic iv, input logic [255:0] cm, input logic last);
        bus.in_valid  = iv;
        bus.cam_match = cm;
        bus.in_last   = last;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [255:0] r_model;
    logic [255:0] ones;

    initial begin
        ones = '1;
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, '0, 1'b0);

        tbl[0]  = mk(1, 32'h4,  0, 0, 0,     0, 0, 1);
        tbl[1]  = mk(1, 32'h8,  0, 0, 0,     0, 0, 1);
        tbl[2]  = mk(1, 32'h10, 0, 0, 0,     0, 0, 1);
        tbl[3]  = mk(1, 32'h1,  1, 1, 32'h10, 3, 0, 0);
        tbl[4]  = mk(0, 32'h0,  0, 1, 32'h1, 1, 1, 1);
        tbl[5]  = mk(0, 32'h0,  0, 0, 0,     0, 0, 1);
        tbl[6]  = mk(1, 32'h0,  1, 1, 0,     0, 1, 1);
        tbl[7]  = mk(1, 32'h0,  0, 1, 0,     0, 0, 1);
        tbl[8]  = mk(1, 32'h3,  0, 0, 0,     0, 0, 1);
        tbl[9]  = mk(1, 32'h6,  0, 0, 0,     0, 0, 1);
        tbl[10] = mk(1, 32'h0,  0, 1, 32'h6, 2, 0, 0);
        tbl[11] = mk(1, 32'hFF, 0, 1, 0,     0, 0, 1);
        tbl[12] = mk(1, 32'h2,  1, 1, 32'h2, 1, 1, 1);
        tbl[13] = mk(1, 32'h1,  0, 0, 0,     0, 0, 1);
        tbl[14] = mk(1, 32'h2,  1, 1, 32'h2, 2, 1, 1);
        tbl[15] = mk(0, 32'h0,  0, 0, 0,     0, 0, 1);
        tbl[16] = mk(1, 32'h1,  0, 0, 0,     0, 0, 1);
        tbl[17] = mk(1, 32'h1,  0, 1, 32'h1, 1, 0, 1);
        tbl[18] = mk(1, 32'h0,  1, 1, 32'h1, 1, 0, 0);
        tbl[19] = mk(0, 32'h0,  0, 1, 0,     0, 1, 1);

        // Reset state
        #2;
        chk("rst.out_valid", 256'(bus.out_valid), 256'(1'b0));
        chk("rst.vec", bus.or_match_vector, '0);
        chk("rst.len", 256'(bus.lm_counter), 256'(8'd0));
        chk("rst.last", 256'(bus.out_last), 256'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready", 256'(bus.in_ready), 256'(1'b1));

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].iv, 256'(tbl[i].cm), tbl[i].last);
            step();
            $display("row %0d: iv=%0d cm=%0h last=%0d -> ov=%0d vec=%0h len=%0d olast=%0d irdy=%0d",
                     i, tbl[i].iv, tbl[i].cm, tbl[i].last, bus.out_valid,
                     bus.or_match_vector, bus.lm_counter, bus.out_last, bus.in_ready);
            chk($sformatf("row%0d.out_valid", i), 256'(bus.out_valid), 256'(tbl[i].ov));
            chk($sformatf("row%0d.in_ready", i), 256'(bus.in_ready), 256'(tbl[i].irdy));
            if (tbl[i].ov) begin
                chk($sformatf("row%0d.vec", i), bus.or_match_vector, 256'(tbl[i].vec));
                chk($sformatf("row%0d.len", i), 256'(bus.lm_counter), 256'(tbl[i].len));
                chk($sformatf("row%0d.last", i), 256'(bus.out_last), 256'(tbl[i].olast));
            end
        end
        drive(1'b0, '0, 1'b0);
        step();

        // Saturating run: 255 diagonal hits, then a top-bit run killed by all-ones
        r_model = 256'd1;
        drive(1'b1, r_model, 1'b0);
        step();
        for (int k = 1; k < 255; k++) begin
            r_model = r_model << 1;
            drive(1'b1, r_model, 1'b0);
            step();
            if (bus.out_valid) chk($sformatf("long.k%0d.out_valid", k), 256'(bus.out_valid), 256'(1'b0));
        end
        chk("long.r_model", r_model, 256'd1 << 254);
        drive(1'b1, 256'd1 << 255, 1'b0);
        step();
        $display("long: saturated token len=%0d", bus.lm_counter);
        chk_tok("long.sat", 256'd1 << 254, 8'd255, 1'b0);
        drive(1'b1, ones, 1'b0);
        step();
        $display("long: top-bit token len=%0d", bus.lm_counter);
        chk_tok("long.topbit", 256'd1 << 255, 8'd1, 1'b0);
        drive(1'b1, '0, 1'b1);
        step();
        chk_tok("long.ones", ones, 8'd1, 1'b0);
        chk("long.ones.in_ready", 256'(bus.in_ready), 256'(1'b0));
        drive(1'b0, '0, 1'b0);
        step();
        chk_tok("long.final", '0, 8'd0, 1'b1);
        step();

        // Back-pressure during a break with a pending literal and a waiting byte
        drive(1'b1, 256'd1, 1'b0);
        step();
        drive(1'b1, '0, 1'b0);
        step();
        chk_tok("bp.break", 256'd1, 8'd1, 1'b0);
        bus.out_ready = 1'b0;
        drive(1'b1, '0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step();
            $display("bp: stall cycle %0d ov=%0d irdy=%0d", c, bus.out_valid, bus.in_ready);
            chk_tok($sformatf("bp.stall%0d", c), 256'd1, 8'd1, 1'b0);
            chk($sformatf("bp.stall%0d.in_ready", c), 256'(bus.in_ready), 256'(1'b0));
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp.release.in_ready", 256'(bus.in_ready), 256'(1'b0));
        step();
        chk_tok("bp.pending", '0, 8'd0, 1'b0);
        chk("bp.pending.in_ready", 256'(bus.in_ready), 256'(1'b1));
        step();
        chk_tok("bp.held_byte", '0, 8'd0, 1'b1);
        drive(1'b0, '0, 1'b0);
        step();
        chk("bp.drain", 256'(bus.out_valid), 256'(1'b0));

        // Reset while a token is pending in FLUSH
        drive(1'b1, 256'd1, 1'b0);
        step();
        drive(1'b1, '0, 1'b0);
        step();
        bus.out_ready = 1'b0;
        drive(1'b0, '0, 1'b0);
        step();
        chk("rf.pre.in_ready", 256'(bus.in_ready), 256'(1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        $display("rf: async reset ov=%0d", bus.out_valid);
        chk("rf.out_valid", 256'(bus.out_valid), 256'(1'b0));
        chk("rf.len", 256'(bus.lm_counter), 256'(8'd0));
        chk("rf.vec", bus.or_match_vector, '0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("rf.post%0d.out_valid", c), 256'(bus.out_valid), 256'(1'b0));
            chk($sformatf("rf.post%0d.in_ready", c), 256'(bus.in_ready), 256'(1'b1));
        end
        drive(1'b1, '0, 1'b1);
        step();
        chk_tok("rf.alive", '0, 8'd0, 1'b1);
        drive(1'b0, '0, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lm_tracker.md
LM_TRACKER -- requirements
Module: lm_tracker

Interface
REQ-001 Parameter CAM_LEN, default `SASA_CAM_len (256), CAM width in entries.
REQ-002 Parameter MAX_LEN, default 255, run-length saturation point (fits the 8-bit counter).
REQ-003 Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte match vector valid.
- in_ready  out  1  byte accepted when in_valid&&in_ready.
- cam_match  in  CAM_LEN  per-entry CAM hit for the current input byte.
- in_last  in  1  current byte ends the stream.
- out_valid  out  1  token valid.
- out_ready  in  1  token consumed when out_valid&&out_ready.
- or_match_vector  out  CAM_LEN  surviving match positions of the finished run (0 for a literal).
- lm_counter  out  8  finished run length (0 = literal).
- out_last  out  1  token is the final one of the stream.

Function
REQ-004 The block SHALL track running vector R and length L; on each accepted byte, next N = (R<<1) & cam_match; bit CAM_LEN-1 of R shifted out is dropped, with no wrap-around.
REQ-005 States SHALL be IDLE (R=0,L=0), MATCH (R!=0), and FLUSH (one pending final token).
REQ-006 IDLE + accepted byte: if cam_match!=0, then R=cam_match, L=1, go MATCH; else emit token (0,0) and stay IDLE.
REQ-007 MATCH + accepted byte with N!=0 and L<MAX_LEN: R=N, L=L+1, no token.
REQ-008 MATCH + accepted byte with N==0: emit token (R,L); the byte restarts a run (R=cam_match, L=cam_match!=0; state MATCH if nonzero, else IDLE with an extra literal token deferred via FLUSH-like pending slot, per REQ-010).
REQ-009 MATCH + accepted byte with N!=0 and L==MAX_LEN: emit token (R,MAX_LEN); restart per REQ-008.
REQ-010 Where one accepted byte produces two tokens (break token plus restarted-literal, or break token plus in_last final token), the first token SHALL go out and the block SHALL enter FLUSH holding the second; in_ready=0 in FLUSH; FLUSH exits to IDLE when the held token is loaded into the output register.
REQ-011 in_last accepted: after applying REQ-006..009, any open run SHALL be emitted with out_last=1 and state SHALL return to IDLE with R=0, L=0; if the byte's only token is a literal, that literal carries out_last=1.
REQ-012 Tokens SHALL be registered: output appears the cycle after the causing acceptance (latency 1); outputs stay stable while out_valid&&!out_ready.
REQ-013 in_ready = (state!=FLUSH) && (!out_valid || out_ready), combinational.
REQ-014 Simultaneous token consume and new token load in one cycle SHALL be lossless, giving back-to-back out_valid.
REQ-015 in_valid while in_ready=0 SHALL have no effect; cam_match is ignored when not accepted.

Reset
REQ-016 rst_n low SHALL asynchronously force state IDLE, R=0, L=0, out_valid=0, or_match_vector=0, lm_counter=0, out_last=0; in_ready reads 1 after release.
REQ-017 Reset mid-run or mid-FLUSH SHALL discard all pending tokens; no token emits on release.

Structure
REQ-018 A shared package SHALL hold CAM_LEN, MAX_LEN, the state enum (IDLE/MATCH/FLUSH), and a token struct {vector, length, last}.
REQ-019 The output register SHALL be a single sub-module lm_token_reg (valid/ready one-entry skid); the FSM and datapath stay in lm_tracker.

Verification
REQ-020 Bytes with cam_match = 0x4, 0x8, 0x10, then 0x1 (in_last on the fourth), out_ready=1 -> first token (0x10, 3, last=0), second token (0x1, 1, last=1).
REQ-021 Single byte with cam_match=0, in_last=1 -> one token (0, 0, last=1) one cycle after acceptance.
REQ-022 Hold bit 0 shifting for 256 continuous matches (cam_match = R<<1 each byte) -> token at L=255 with R=1<<254, then the run restarts.
REQ-023 R = 1<<(CAM_LEN-1), next cam_match all-ones -> N=0, token (1<<255, L) emitted, and the new run starts with L=1.
REQ-024 Hold out_ready=0 for 5 cycles during a break -> in_ready=0, the token stays stable, and no byte is lost after release.
REQ-025 Assert rst_n low while in FLUSH -> out_valid=0 immediately and asynchronously, with no token after release.
